// File: rtl/f_pc_npc_pkg.sv
// Shared constants for the fetch-stage PC / next-PC unit.
//   RESET_PC  : PC loaded by reset
//   EXC_PC    : exception handler entry
//   IM_LO/HI  : legal instruction fetch window, inclusive
//   EXC_*     : CP0 exception codes raised by fetch
//   npc_op_e  : D-stage control-flow class
package f_pc_npc_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6ffc;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_e;

  // A fetch address is illegal if misaligned or outside the IM window.
  function automatic logic fetch_addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < IM_LO) || (addr > IM_HI);
  endfunction

endpackage

// File: rtl/f_pc_npc_calc.sv
// Purely combinational next-PC selection.
//   f_pc        : current fetch address
//   stall_f     : hold request
//   d_npc_op    : D-stage control-flow class (npc_op_e encoding)
//   d_jump_b    : branch comparator result, only meaningful for NPC_BR
//   d_pc        : PC of the D-stage instruction
//   d_imm16     : branch offset field
//   d_index26   : j/jal target index
//   d_rs        : jr/jalr target
//   exc_req     : exception taken this cycle
//   eret        : ERET in D this cycle
//   epc         : ERET return address
//   npc         : value the PC register loads at the next edge
module npc_calc
  import f_pc_npc_pkg::*;
(
  input  logic [31:0] f_pc,
  input  logic        stall_f,
  input  logic [1:0]  d_npc_op,
  input  logic        d_jump_b,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_index26,
  input  logic [31:0] d_rs,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] npc
);

  npc_op_e     op;
  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] j_pc;

  assign op     = npc_op_e'(d_npc_op);
  assign seq_pc = f_pc + 32'd4;
  // Branch target is relative to the delay slot (d_pc + 4); wraps modulo 2^32.
  assign br_pc  = d_pc + 32'd4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign j_pc   = {d_pc[31:28], d_index26, 2'b00};

  // CP0 redirects sit above the stall so they take effect even while held.
  always_comb begin
    npc = seq_pc;
    if (exc_req) begin
      npc = EXC_PC;
    end else if (eret) begin
      npc = epc;
    end else if (stall_f) begin
      npc = f_pc;
    end else if (op == NPC_BR && d_jump_b) begin
      npc = br_pc;
    end else if (op == NPC_J) begin
      npc = j_pc;
    end else if (op == NPC_JR) begin
      npc = d_rs;
    end
  end

endmodule

// File: rtl/f_pc_npc.sv
// Fetch-stage program counter with next-PC selection and fetch flags.
//   clk, reset  : clock; asynchronous active-high reset
//   stall_f     : hold the PC
//   d_*         : D-stage control-flow decision and target operands
//   exc_req     : CP0 exception redirect
//   eret, epc   : return from exception
//   f_pc        : fetch address
//   f_excode    : EXC_ADEL when the fetch address is illegal, else 0
//   f_bd        : fetched instruction is a branch delay slot
//   flush_fd    : kill the F->D register at the next edge
module f_pc_npc
  import f_pc_npc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic [1:0]  d_npc_op,
  input  logic        d_jump_b,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_index26,
  input  logic [31:0] d_rs,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] f_pc,
  output logic [4:0]  f_excode,
  output logic        f_bd,
  output logic        flush_fd
);

  logic [31:0] npc;

  npc_calc u_npc_calc (
    .f_pc      (f_pc),
    .stall_f   (stall_f),
    .d_npc_op  (d_npc_op),
    .d_jump_b  (d_jump_b),
    .d_pc      (d_pc),
    .d_imm16   (d_imm16),
    .d_index26 (d_index26),
    .d_rs      (d_rs),
    .exc_req   (exc_req),
    .eret      (eret),
    .epc       (epc),
    .npc       (npc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc <= RESET_PC;
    end else begin
      f_pc <= npc;
    end
  end

  // Illegal fetches still advance the PC; downstream substitutes a nop.
  assign f_excode = fetch_addr_bad(f_pc) ? EXC_ADEL : EXC_NONE;

  // Any branch or jump in D makes the instruction now in F its delay slot,
  // whether or not the branch is taken.
  assign f_bd = (npc_op_e'(d_npc_op) != NPC_SEQ);

  // ERET has no delay slot; an exception in the same cycle leaves flushing to CP0.
  assign flush_fd = eret & ~exc_req;

endmodule

// File: tb/tb_f_pc_npc.sv
module tb_f_pc_npc;

  localparam logic [31:0] T_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] T_EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] T_LO       = 32'h0000_3000;
  localparam logic [31:0] T_HI       = 32'h0000_6ffc;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic [1:0]  d_npc_op;
  logic        d_jump_b;
  logic [31:0] d_pc;
  logic [15:0] d_imm16;
  logic [25:0] d_index26;
  logic [31:0] d_rs;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] f_pc;
  logic [4:0]  f_excode;
  logic        f_bd;
  logic        flush_fd;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_pc;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  f_pc_npc dut (
    .clk       (clk),
    .reset     (reset),
    .stall_f   (stall_f),
    .d_npc_op  (d_npc_op),
    .d_jump_b  (d_jump_b),
    .d_pc      (d_pc),
    .d_imm16   (d_imm16),
    .d_index26 (d_index26),
    .d_rs      (d_rs),
    .exc_req   (exc_req),
    .eret      (eret),
    .epc       (epc),
    .f_pc      (f_pc),
    .f_excode  (f_excode),
    .f_bd      (f_bd),
    .flush_fd  (flush_fd)
  );

  // reference model: next fetch address from the control-flow rules
  function automatic logic [31:0] model_next(input logic [31:0] pc);
    int signed off;
    if (exc_req) return T_EXC_PC;
    if (eret) return epc;
    if (stall_f) return pc;
    case (d_npc_op)
      2'd1: begin
        off = $signed({{16{d_imm16[15]}}, d_imm16}) * 4;
        if (d_jump_b) return d_pc + 32'd4 + 32'(off);
        return pc + 32'd4;
      end
      2'd2: return (d_pc & 32'hf000_0000) | (32'(d_index26) * 4);
      2'd3: return d_rs;
      default: return pc + 32'd4;
    endcase
  endfunction

  function automatic logic [4:0] model_excode(input logic [31:0] pc);
    if ((pc % 4) != 0 || pc < T_LO || pc > T_HI) return 5'd4;
    return 5'd0;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_idle();
    stall_f = 0; d_npc_op = 2'd0; d_jump_b = 0; d_pc = 32'h0;
    d_imm16 = 16'h0; d_index26 = 26'h0; d_rs = 32'h0;
    exc_req = 0; eret = 0; epc = 32'h0;
  endtask

  // Inputs are already applied; check the combinational flags, then clock
  // one edge and compare the new PC against the scoreboard.
  task automatic cycle(input string tag);
    #1;
    check32({tag, ".excode"}, 32'(f_excode), 32'(model_excode(m_pc)));
    check32({tag, ".bd"}, 32'(f_bd), 32'(d_npc_op != 2'd0));
    check32({tag, ".flush"}, 32'(flush_fd), 32'(eret && !exc_req));
    exp_q.push_back(model_next(m_pc));
    m_pc = exp_q[$];
    @(posedge clk);
    #1;
    check32({tag, ".pc"}, f_pc, exp_q.pop_front());
  endtask

  initial begin
    reset = 1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    m_pc = T_RESET_PC;
    check32("rst.pc", f_pc, T_RESET_PC);
    check32("rst.excode", 32'(f_excode), 32'd0);
    check32("rst.bd", 32'(f_bd), 32'd0);
    check32("rst.flush", 32'(flush_fd), 32'd0);
    @(negedge clk);
    reset = 0;

    // sequential fetch
    repeat (3) cycle("seq");
    check32("seq.abs", f_pc, 32'h300c);

    // taken branch backwards
    d_npc_op = 2'd1; d_pc = 32'h3010; d_imm16 = 16'hfffe; d_jump_b = 1;
    cycle("br_t");
    check32("br_t.abs", f_pc, 32'h300c);
    // not-taken branch falls through
    d_jump_b = 0;
    cycle("br_nt");

    // jump then misaligned jr
    d_npc_op = 2'd2; d_pc = 32'h3020; d_index26 = 26'h0000d00;
    cycle("j");
    check32("j.abs", f_pc, 32'h3400);
    d_npc_op = 2'd3; d_rs = 32'h3001;
    cycle("jr");
    check32("jr.abs", f_pc, 32'h3001);
    set_idle();
    cycle("adel");

    // stall with a taken branch, then release
    d_npc_op = 2'd1; d_pc = 32'h3100; d_imm16 = 16'h0010; d_jump_b = 1; stall_f = 1;
    cycle("stall0");
    cycle("stall1");
    stall_f = 0;
    cycle("release");
    check32("release.abs", f_pc, 32'h3144);

    // exception beats stall, eret, exception+eret
    set_idle(); stall_f = 1; exc_req = 1;
    cycle("exc_stall");
    check32("exc.abs", f_pc, 32'h4180);
    set_idle(); eret = 1; epc = 32'h3044;
    cycle("eret");
    check32("eret.abs", f_pc, 32'h3044);
    exc_req = 1;
    cycle("exc_eret");
    set_idle();
    cycle("idle");

    // asynchronous reset between edges, mid-redirect
    d_npc_op = 2'd3; d_rs = 32'h5000;
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    m_pc = T_RESET_PC;
    check32("async_rst.pc", f_pc, T_RESET_PC);
    check32("async_rst.excode", 32'(f_excode), 32'd0);
    @(negedge clk);
    reset = 0;
    set_idle();
    cycle("post_rst");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      set_idle();
      stall_f   = ($urandom_range(0, 3) == 0);
      d_npc_op  = 2'($urandom_range(0, 3));
      d_jump_b  = 1'($urandom_range(0, 1));
      d_pc      = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
      d_imm16   = 16'($urandom);
      d_index26 = ($urandom_range(0, 7) == 0) ? 26'($urandom)
                                              : 26'(32'h0c00 + $urandom_range(0, 4095));
      d_rs      = ($urandom_range(0, 7) == 0) ? $urandom
                                              : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
      exc_req   = ($urandom_range(0, 15) == 0);
      eret      = ($urandom_range(0, 15) == 0);
      epc       = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
